add_sub_seq: RTL

//  Parametrised multi-cycle adder/subtractor; processes WIDTH-bit operands CHUNK bits per cycle.

---
 rtl/add_sub_seq_pkg.sv | 18 +
 rtl/add_sub_seq_add_chunk.sv | 28 ++
 rtl/add_sub_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/add_sub_seq_pkg.sv
// Shared FSM states, operation codes and sizing helper for the chunked adder/subtractor.
package add_sub_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Index counter width: clog2 of the chunk count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_sub_seq_add_chunk.sv
// CHUNK-bit ripple adder; also reports the carry into its top bit for signed overflow.
module add_sub_seq_add_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] cy;

  always_comb begin
    cy    = '0;
    sum   = '0;
    cy[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]  = a[i] ^ b[i] ^ cy[i];
      cy[i+1] = (a[i] & b[i]) | (a[i] & cy[i]) | (b[i] & cy[i]);
    end
  end

  assign cout     = cy[CHUNK];
  assign c_msb_in = cy[CHUNK-1];

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle through a single shared
// ripple adder, carry held in a register between slices, valid/ready on both sides.
module add_sub_seq
  import add_sub_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CHUNK   = 8,
  parameter int ABS_OUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             overflow,
  output logic             zero,
  output logic             neg
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout;
  logic             ch_cmsb;
  logic [WIDTH-1:0] sum_full;
  logic [WIDTH-1:0] mag;

  add_sub_seq_add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (a_q[int'(idx)*CHUNK +: CHUNK]),
    .b        (b_q[int'(idx)*CHUNK +: CHUNK]),
    .cin      (carry_q),
    .sum      (ch_sum),
    .cout     (ch_cout),
    .c_msb_in (ch_cmsb)
  );

  // Partial sum with the current slice merged in; complete once idx reaches LAST.
  always_comb begin
    sum_full = sum_q;
    sum_full[int'(idx)*CHUNK +: CHUNK] = ch_sum;
  end

  // Most negative value wraps to itself, matching WIDTH-bit two's-complement negation.
  assign mag = sum_full[WIDTH-1] ? (~sum_full + WIDTH'(1)) : sum_full;

  assign in_ready = (state == ST_IDLE) && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      result    <= '0;
      c         <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= (sub == OP_ADD) ? b : ~b;
            carry_q <= (sub == OP_SUB);
            sum_q   <= '0;
            idx     <= '0;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          sum_q   <= sum_full;
          carry_q <= ch_cout;
          if (idx == LAST) begin
            result    <= (ABS_OUT != 0) ? mag : sum_full;
            c         <= ch_cout;
            overflow  <= ch_cout ^ ch_cmsb;
            zero      <= (sum_full == '0);
            neg       <= sum_full[WIDTH-1];
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
